// File: rtl/regbank_pkg.sv
// Shared types and constants for the arbitrated register bank read path.
package regbank_pkg;

  localparam int DEFAULT_NUM_REQ     = 4;
  localparam int DEFAULT_NUM_ENTRIES = 8;
  localparam int DEFAULT_DATA_W      = 32;
  localparam int DEFAULT_ADDR_W      = $clog2(DEFAULT_NUM_ENTRIES);
  localparam int DEFAULT_ID_W        = $clog2(DEFAULT_NUM_REQ);

  typedef logic [DEFAULT_DATA_W-1:0] entry_t;
  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
  typedef logic [DEFAULT_ID_W-1:0]   req_id_t;

  // Value the response slot and every bank entry return to on reset,
  // and the value read back from an address outside the bank.
  localparam entry_t RSP_RESET_DATA = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants at most one requester per cycle, scanning
// upward from a rotating priority pointer that it owns.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               grant_valid
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr;

  // Pick the first active requester at or after ptr, wrapping around.
  always_comb begin
    int idx;
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    if (enable) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_REQ) begin
          idx = idx - NUM_REQ;
        end
        if (!grant_valid && req[idx]) begin
          grant_valid = 1'b1;
          grant[idx]  = 1'b1;
          grant_id    = idx[ID_W-1:0];
        end
      end
    end
  end

  // Move priority to the requester just after the one that won.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
    end
  end

endmodule

// File: rtl/regbank_read_arbiter.sv
// Register bank with one write port and one round-robin arbitrated read
// port whose result lands in a single registered response slot.
module regbank_read_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REQ     = DEFAULT_NUM_REQ,
  parameter int NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ADDR_W      = $clog2(NUM_ENTRIES),
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IN_wen,
  input  logic [ADDR_W-1:0]              IN_waddr,
  input  logic [DATA_W-1:0]              IN_wdata,
  input  logic [NUM_REQ-1:0]             IN_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] IN_req_addr,
  output logic [NUM_REQ-1:0]             OUT_req_ready,
  output logic                           OUT_rsp_valid,
  output logic [ID_W-1:0]                OUT_rsp_id,
  output logic [DATA_W-1:0]              OUT_rsp_data,
  input  logic                           IN_rsp_ready
);

  localparam logic [ADDR_W:0]   ENTRY_LIMIT = (ADDR_W + 1)'(NUM_ENTRIES);
  localparam logic [DATA_W-1:0] RESET_DATA  = DATA_W'(RSP_RESET_DATA);

  logic [DATA_W-1:0] mem [NUM_ENTRIES];

  logic              slot_free;
  logic              arb_enable;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   grant_id;
  logic              grant_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] read_data;
  logic              waddr_ok;

  // The slot can accept a new read when empty or being drained this cycle;
  // requests seen while reset is held are never granted.
  assign slot_free  = !OUT_rsp_valid || IN_rsp_ready;
  assign arb_enable = slot_free && !rst;
  assign waddr_ok   = ({1'b0, IN_waddr} < ENTRY_LIMIT);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (IN_req_valid),
    .enable      (arb_enable),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  assign OUT_req_ready = grant;
  assign sel_addr      = IN_req_addr[grant_id];

  // Read mux with write-first bypass; addresses past the bank read as zero.
  always_comb begin
    read_data = RESET_DATA;
    if ({1'b0, sel_addr} < ENTRY_LIMIT) begin
      if (IN_wen && (IN_waddr == sel_addr)) begin
        read_data = IN_wdata;
      end else begin
        read_data = mem[sel_addr];
      end
    end
  end

  // Bank storage: cleared on reset, single write port that never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem[i] <= RESET_DATA;
      end
    end else if (IN_wen && waddr_ok) begin
      mem[IN_waddr] <= IN_wdata;
    end
  end

  // Response slot: load on grant, hold under backpressure, drop valid on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_rsp_valid <= 1'b0;
      OUT_rsp_id    <= '0;
      OUT_rsp_data  <= RESET_DATA;
    end else if (grant_valid) begin
      OUT_rsp_valid <= 1'b1;
      OUT_rsp_id    <= grant_id;
      OUT_rsp_data  <= read_data;
    end else if (IN_rsp_ready) begin
      OUT_rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regbank_read_arbiter.sv
// Directed, table-driven bench for the arbitrated register bank read port.
module tb_regbank_read_arbiter;

  logic             clk;
  logic             rst;
  logic             IN_wen;
  logic [2:0]       IN_waddr;
  logic [31:0]      IN_wdata;
  logic [3:0]       IN_req_valid;
  logic [3:0][2:0]  IN_req_addr;
  logic [3:0]       OUT_req_ready;
  logic             OUT_rsp_valid;
  logic [1:0]       OUT_rsp_id;
  logic [31:0]      OUT_rsp_data;
  logic             IN_rsp_ready;

  int checks;
  int failures;

  typedef struct {
    logic            wen;
    logic [2:0]      waddr;
    logic [31:0]     wdata;
    logic [3:0]      req_valid;
    logic [3:0][2:0] req_addr;
    logic            rsp_ready;
    logic [3:0]      exp_ready;
    logic            exp_valid;
    logic [1:0]      exp_id;
    logic [31:0]     exp_data;
  } vector_t;

  vector_t vecs[$];

  regbank_read_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .IN_wen        (IN_wen),
    .IN_waddr      (IN_waddr),
    .IN_wdata      (IN_wdata),
    .IN_req_valid  (IN_req_valid),
    .IN_req_addr   (IN_req_addr),
    .OUT_req_ready (OUT_req_ready),
    .OUT_rsp_valid (OUT_rsp_valid),
    .OUT_rsp_id    (OUT_rsp_id),
    .OUT_rsp_data  (OUT_rsp_data),
    .IN_rsp_ready  (IN_rsp_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vector_t mk(input logic wen, input logic [2:0] waddr, input logic [31:0] wdata,
                                 input logic [3:0] rv, input logic [3:0][2:0] ra, input logic rr,
                                 input logic [3:0] er, input logic ev, input logic [1:0] eid,
                                 input logic [31:0] ed);
    vector_t v;
    v.wen = wen; v.waddr = waddr; v.wdata = wdata;
    v.req_valid = rv; v.req_addr = ra; v.rsp_ready = rr;
    v.exp_ready = er; v.exp_valid = ev; v.exp_id = eid; v.exp_data = ed;
    return v;
  endfunction

  // Drive one cycle at the falling edge, check the grant before the rising
  // edge and the response slot just after it.
  task automatic applyStimulus(input vector_t v, input int n);
    @(negedge clk);
    IN_wen       = v.wen;
    IN_waddr     = v.waddr;
    IN_wdata     = v.wdata;
    IN_req_valid = v.req_valid;
    IN_req_addr  = v.req_addr;
    IN_rsp_ready = v.rsp_ready;
    #1;
    checkOutput($sformatf("v%0d req_ready", n), 32'(OUT_req_ready), 32'(v.exp_ready));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d rsp_valid", n), 32'(OUT_rsp_valid), 32'(v.exp_valid));
    if (v.exp_valid) begin
      checkOutput($sformatf("v%0d rsp_id", n), 32'(OUT_rsp_id), 32'(v.exp_id));
      checkOutput($sformatf("v%0d rsp_data", n), OUT_rsp_data, v.exp_data);
    end
  endtask

  initial begin
    logic [3:0][2:0] all_addr;
    checks   = 0;
    failures = 0;
    all_addr = {3'd3, 3'd5, 3'd0, 3'd5};

    // Stream after the reset sequence; ptr starts at 1 there, slot holds id0.
    vecs.push_back(mk(1, 3'd5, 32'hDEADBEEF, 4'b0000, '0,       1, 4'b0000, 0, 2'd0, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 1, 4'b0100, 1, 2'd2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b1000, all_addr, 1, 4'b1000, 1, 2'd3, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b1111, all_addr, 1, 4'b0001, 1, 2'd0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b1111, all_addr, 1, 4'b0010, 1, 2'd1, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b1111, all_addr, 1, 4'b0100, 1, 2'd2, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b1111, all_addr, 1, 4'b1000, 1, 2'd3, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b1111, all_addr, 1, 4'b0001, 1, 2'd0, 32'hDEADBEEF));
    vecs.push_back(mk(1, 3'd1, 32'h11111111, 4'b0010, {3'd0, 3'd0, 3'd1, 3'd0}, 1, 4'b0010, 1, 2'd1, 32'h11111111));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0010, {3'd0, 3'd0, 3'd1, 3'd0}, 1, 4'b0010, 1, 2'd1, 32'h11111111));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 0, 4'b0000, 1, 2'd1, 32'h11111111));
    vecs.push_back(mk(1, 3'd1, 32'h22222222, 4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 0, 4'b0000, 1, 2'd1, 32'h11111111));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 0, 4'b0000, 1, 2'd1, 32'h11111111));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0001, {3'd0, 3'd0, 3'd0, 3'd1}, 1, 4'b0001, 1, 2'd0, 32'h22222222));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0000, '0,       0, 4'b0000, 1, 2'd0, 32'h22222222));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0000, '0,       1, 4'b0000, 0, 2'd0, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        4'b0100, {3'd0, 3'd1, 3'd0, 3'd0}, 1, 4'b0100, 1, 2'd2, 32'h22222222));

    // Reset with every requester asking: no grant, empty slot.
    rst          = 1'b1;
    IN_wen       = 1'b0;
    IN_waddr     = '0;
    IN_wdata     = '0;
    IN_req_valid = 4'b1111;
    IN_req_addr  = {3'd0, 3'd0, 3'd0, 3'd3};
    IN_rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst req_ready", 32'(OUT_req_ready), 32'h0);
    checkOutput("rst rsp_valid", 32'(OUT_rsp_valid), 32'h0);
    checkOutput("rst rsp_data", OUT_rsp_data, 32'h0);

    // First cycle out of reset grants req0; entry 3 reads as zero.
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-rst req_ready", 32'(OUT_req_ready), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("post-rst rsp_valid", 32'(OUT_rsp_valid), 32'h1);
    checkOutput("post-rst rsp_id", 32'(OUT_rsp_id), 32'h0);
    checkOutput("post-rst rsp_data", OUT_rsp_data, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Reset while a response is pending: it is lost and the slot clears.
    @(negedge clk);
    rst          = 1'b1;
    IN_wen       = 1'b0;
    IN_req_valid = 4'b1111;
    IN_rsp_ready = 1'b0;
    #1;
    checkOutput("rst2 req_ready", 32'(OUT_req_ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst2 rsp_valid", 32'(OUT_rsp_valid), 32'h0);
    checkOutput("rst2 rsp_id", 32'(OUT_rsp_id), 32'h0);
    checkOutput("rst2 rsp_data", OUT_rsp_data, 32'h0);

    // Pointer back at req0, and entry 5 was cleared by the reset.
    @(negedge clk);
    rst          = 1'b0;
    IN_req_valid = 4'b1111;
    IN_req_addr  = {3'd1, 3'd1, 3'd1, 3'd5};
    IN_rsp_ready = 1'b1;
    #1;
    checkOutput("rst2 grant req0", 32'(OUT_req_ready), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("rst2 after rsp_valid", 32'(OUT_rsp_valid), 32'h1);
    checkOutput("rst2 after rsp_id", 32'(OUT_rsp_id), 32'h0);
    checkOutput("rst2 after entry5", OUT_rsp_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regbank_read_arbiter.md
Name: regbank_read_arbiter

Overview:
- 8-entry x 32-bit register bank with one write port and one shared, arbitrated read port.
- NUM_REQ requesters compete for the read port; a round-robin arbiter grants at most one read per cycle.
- Read data returns through a registered response slot with valid/ready backpressure.
- Sits in front of the bank's read muxtree, so consumers never drive the read address directly.

Parameters:
- NUM_REQ, 4, number of read requesters (2..8).
- NUM_ENTRIES, 8, bank depth.
- DATA_W, 32, entry width in bits.
- ADDR_W, $clog2(NUM_ENTRIES), entry address width.
- ID_W, $clog2(NUM_REQ), width of the requester id.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- IN_wen  in  1  write enable.
- IN_waddr  in  ADDR_W  write entry index.
- IN_wdata  in  DATA_W  write data.
- IN_req_valid  in  NUM_REQ  per-requester read request.
- IN_req_addr  in  NUM_REQ x ADDR_W  per-requester read index.
- OUT_req_ready  out  NUM_REQ  one-hot grant; the request is accepted this cycle.
- OUT_rsp_valid  out  1  response slot holds valid data.
- OUT_rsp_id  out  ID_W  requester that owns the response.
- OUT_rsp_data  out  DATA_W  read data.
- IN_rsp_ready  in  1  consumer accepts the response.

Behaviour:
- Reset: all entries 0, OUT_rsp_valid 0, OUT_rsp_id 0, OUT_rsp_data 0, rr pointer 0. Any request in flight during reset is dropped.
- Write: when IN_wen=1, entry[IN_waddr] takes IN_wdata at the edge. The write port never stalls.
- Slot free: slot_free = !OUT_rsp_valid || IN_rsp_ready.
- Grant, combinational:
  - If slot_free, grant the first requester with IN_req_valid=1, scanning from ptr upward and wrapping modulo NUM_REQ.
  - Otherwise grant nothing. OUT_req_ready is all-zero when not slot_free.
  - OUT_req_ready never depends on IN_rsp_ready in any other way.
- Pointer: on a grant to requester i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds.
- Response latency is exactly 1 cycle. On a grant at edge N:
  - OUT_rsp_valid=1 after edge N.
  - OUT_rsp_id = i.
  - OUT_rsp_data = value of entry[IN_req_addr[i]] at grant time.
- Read-during-write: if IN_wen=1 and IN_waddr equals the granted address in the same cycle, OUT_rsp_data = IN_wdata (write-first bypass).
- Hold: while OUT_rsp_valid=1 and IN_rsp_ready=0, id and data are frozen. A later write to that entry does not change the held data.
- Drain: IN_rsp_ready=1 with no new grant gives OUT_rsp_valid <= 0. Data and id keep their last values (don't-care).
- Back-to-back: IN_rsp_ready=1 together with a new grant replaces the slot in the same edge. Full throughput is 1 read/cycle.
- Requesters must hold valid and addr stable until granted. The block does not check this.
- Out-of-range addr (>= NUM_ENTRIES when NUM_ENTRIES is not a power of 2): write ignored, read returns 0.

Decomposition:
- Package regbank_pkg:
  - typedefs entry_t (logic[DATA_W-1:0]), addr_t, req_id_t.
  - constant RSP_RESET_DATA = 0.
- Sub-module rr_arbiter (NUM_REQ). Inputs: req vector, enable (= slot_free). Outputs: one-hot grant and encoded id. It owns the ptr register and its clk/rst.
- The bank storage and read mux stay in the top module.

Test Plan:
- Reset with all requests active -> OUT_rsp_valid=0, OUT_req_ready=0 during rst. First cycle after reset: grant to req0. Reading entry 3 returns 0.
- Write entry 5=0xDEADBEEF, next cycle req2 reads addr 5 -> OUT_req_ready=4'b0100; one cycle later rsp_valid=1, id=2, data=0xDEADBEEF.
- All 4 requesters valid continuously, IN_rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp ids follow one cycle later with no bubbles.
- Same-cycle write entry 1=0x11111111 and req1 read addr 1 -> response data 0x11111111 (bypass).
- Response held with IN_rsp_ready=0 for 3 cycles while req0 valid -> OUT_req_ready=0 for those cycles. Data stays stable even when the same entry is rewritten. Raising IN_rsp_ready grants req0 in that same cycle.
- Assert rst while OUT_rsp_valid=1 -> next cycle OUT_rsp_valid=0, ptr=0, entries 0, and the pending response is lost.
